// File: rtl/matrix_input_subsystem.sv
`default_nettype none
// ============================================================================
// Module      : matrix_input_subsystem
// Description : Parses an ASCII matrix ("m n" header followed by m*n
//               single-digit elements) from the UART receive byte stream and
//               writes each element, row-major, into matrix storage as a
//               zero-extended 32-bit word. Start/done handshake with the FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_input_subsystem #(
  parameter int MAX_DIM = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        w_en_input,
  input  logic [7:0]  w_in_base_addr,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        w_in_wr_en,
  output logic [7:0]  w_in_wr_addr,
  output logic [31:0] w_in_wr_data,
  output logic [31:0] w_in_m,
  output logic [31:0] w_in_n,
  output logic        w_in_done,
  output logic        w_in_err,
  output logic [1:0]  w_in_err_code
);

  localparam logic [3:0] c_max_dim     = 4'(MAX_DIM);
  localparam logic [1:0] c_err_illegal = 2'd1;
  localparam logic [1:0] c_err_range   = 2'd2;
  localparam logic [1:0] c_err_adjacent = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GET_M    = 3'd1,
    S_GET_N    = 3'd2,
    S_GET_ELEM = 3'd3,
    S_WRITE    = 3'd4,
    S_DONE     = 3'd5,
    S_ERR      = 3'd6
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_base, w_base_nxt;
  logic [7:0] r_idx, w_idx_nxt;
  logic [3:0] r_m, w_m_nxt;
  logic [3:0] r_n, w_n_nxt;
  logic [3:0] r_value, w_value_nxt;
  logic       r_tok, w_tok_nxt;
  logic [1:0] r_code, w_code_nxt;

  logic       w_is_digit;
  logic       w_is_sep;
  logic [3:0] w_digit;
  logic       w_dim_ok;
  logic [7:0] w_total;
  logic       w_last;

  // Byte classification; ASCII digits are 0x30..0x39, so the low nibble is the value.
  assign w_is_digit = (rx_data >= 8'd48) && (rx_data <= 8'd57);
  assign w_is_sep   = (rx_data == 8'd32) || (rx_data == 8'd13) || (rx_data == 8'd10);
  assign w_digit    = rx_data[3:0];
  assign w_dim_ok   = (w_digit != 4'd0) && (w_digit <= c_max_dim);
  assign w_total    = {4'b0, r_m} * {4'b0, r_n};
  assign w_last     = (r_idx == w_total - 8'd1);

  // State and datapath registers; reset drops any partial parse without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_base  <= 8'd0;
      r_idx   <= 8'd0;
      r_m     <= 4'd0;
      r_n     <= 4'd0;
      r_value <= 4'd0;
      r_tok   <= 1'b0;
      r_code  <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_base  <= w_base_nxt;
      r_idx   <= w_idx_nxt;
      r_m     <= w_m_nxt;
      r_n     <= w_n_nxt;
      r_value <= w_value_nxt;
      r_tok   <= w_tok_nxt;
      r_code  <= w_code_nxt;
    end
  end

  // Next-state and parse logic: a separator always clears the token flag, a digit
  // while the flag is set is an adjacency error, anything else is illegal.
  always_comb begin
    w_state_nxt = r_state;
    w_base_nxt  = r_base;
    w_idx_nxt   = r_idx;
    w_m_nxt     = r_m;
    w_n_nxt     = r_n;
    w_value_nxt = r_value;
    w_tok_nxt   = r_tok;
    w_code_nxt  = r_code;
    case (r_state)
      S_IDLE: begin
        if (w_en_input) begin
          w_base_nxt  = w_in_base_addr;
          w_idx_nxt   = 8'd0;
          w_tok_nxt   = 1'b0;
          w_code_nxt  = 2'd0;
          w_state_nxt = S_GET_M;
        end
      end
      S_GET_M, S_GET_N, S_GET_ELEM: begin
        if (rx_valid) begin
          if (w_is_sep) begin
            w_tok_nxt = 1'b0;
          end else if (!w_is_digit) begin
            w_code_nxt  = c_err_illegal;
            w_state_nxt = S_ERR;
          end else if (r_tok) begin
            w_code_nxt  = c_err_adjacent;
            w_state_nxt = S_ERR;
          end else if (r_state == S_GET_ELEM) begin
            w_value_nxt = w_digit;
            w_tok_nxt   = 1'b1;
            w_state_nxt = S_WRITE;
          end else if (!w_dim_ok) begin
            w_code_nxt  = c_err_range;
            w_state_nxt = S_ERR;
          end else begin
            w_tok_nxt = 1'b1;
            if (r_state == S_GET_M) begin
              w_m_nxt     = w_digit;
              w_state_nxt = S_GET_N;
            end else begin
              w_n_nxt     = w_digit;
              w_state_nxt = S_GET_ELEM;
            end
          end
        end
      end
      S_WRITE: begin
        w_idx_nxt = r_idx + 8'd1;
        if (w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          // A byte landing on the write cycle is treated as arriving in GET_ELEM
          // right after the write, where the token flag is already set.
          w_state_nxt = S_GET_ELEM;
          w_tok_nxt   = 1'b1;
          if (rx_valid) begin
            if (w_is_sep) begin
              w_tok_nxt = 1'b0;
            end else if (!w_is_digit) begin
              w_code_nxt  = c_err_illegal;
              w_state_nxt = S_ERR;
            end else begin
              w_code_nxt  = c_err_adjacent;
              w_state_nxt = S_ERR;
            end
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      S_ERR:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs decode from state so every strobe is exactly one cycle wide.
  assign w_in_wr_en    = (r_state == S_WRITE);
  assign w_in_wr_addr  = w_in_wr_en ? (r_base + r_idx) : 8'd0;
  assign w_in_wr_data  = w_in_wr_en ? {28'b0, r_value} : 32'd0;
  assign w_in_m        = {28'b0, r_m};
  assign w_in_n        = {28'b0, r_n};
  assign w_in_done     = (r_state == S_DONE) || (r_state == S_ERR);
  assign w_in_err      = (r_state == S_ERR);
  assign w_in_err_code = w_in_err ? r_code : 2'd0;

endmodule
`default_nettype wire
